// File: rtl/video_pipeline_pkg.sv
// video_pipeline_pkg: shared geometry derivations and FSM encodings for the scaler pipeline
package video_pipeline_pkg;
  typedef enum logic [2:0] {
    REQ_IDLE  = 3'b001,
    REQ_READ  = 3'b010,
    REQ_STORE = 3'b100
  } req_state_e;
  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_FETCH,
    RESP_EMIT
  } resp_state_e;
  function automatic int chunknum_bits(input int hactive_bits, input int chunk_bits);
    return hactive_bits - chunk_bits;
  endfunction
  function automatic int request_bits(input int vactive_bits, input int hactive_bits, input int chunk_bits);
    return vactive_bits + chunknum_bits(hactive_bits, chunk_bits);
  endfunction
endpackage

// File: rtl/SyncFifo.sv
// SyncFifo: single-clock FIFO with synchronous reset and registered (1-cycle) read data
module SyncFifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);
  logic [WIDTH-1:0]     mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]   cnt_q;
  logic [WIDTH-1:0]     rd_data_q;
  logic                 push, pop;
  assign empty_o   = cnt_q == '0;
  assign full_o    = cnt_q[ADDR_BITS];
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = rd_data_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_BITS'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      cnt_q <= cnt_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
    end
endmodule

// File: rtl/video_pad_crop_filter.sv
// video_pad_crop_filter: crops/pads {row, chunk} requests against a window, forwarding upstream pixels or pad colour
module video_pad_crop_filter
  import video_pipeline_pkg::*;
#(
  parameter int CHUNK_BITS         = 5,
  parameter int HACTIVE_BITS       = 11,
  parameter int VACTIVE_BITS       = 11,
  parameter int BITS_PER_PIXEL     = 16,
  parameter int REQ_FIFO_ADDR_BITS = HACTIVE_BITS - CHUNK_BITS,
  parameter int PIX_FIFO_ADDR_BITS = CHUNK_BITS + 1
) (
  input  logic                                        scalerClock,
  input  logic                                        reset,
  input  logic                                        bypass,
  input  logic [VACTIVE_BITS-1:0]                     padTopRows,
  input  logic [HACTIVE_BITS-CHUNK_BITS-1:0]          padLeftChunks,
  input  logic [VACTIVE_BITS-1:0]                     sourceRows,
  input  logic [HACTIVE_BITS-CHUNK_BITS-1:0]          sourceChunks,
  input  logic [BITS_PER_PIXEL-1:0]                   padColor,
  output logic                                        downstreamRequestFifoReadEnable,
  input  logic                                        downstreamRequestFifoEmpty,
  input  logic [VACTIVE_BITS+HACTIVE_BITS-CHUNK_BITS-1:0] downstreamRequestFifoReadData,
  output logic                                        downstreamResponseFifoWriteEnable,
  input  logic                                        downstreamResponseFifoFull,
  output logic [BITS_PER_PIXEL-1:0]                   downstreamResponseFifoWriteData,
  input  logic                                        upstreamRequestFifoReadEnable,
  output logic                                        upstreamRequestFifoEmpty,
  output logic [VACTIVE_BITS+HACTIVE_BITS-CHUNK_BITS-1:0] upstreamRequestFifoReadData,
  input  logic                                        upstreamResponseFifoWriteEnable,
  output logic                                        upstreamResponseFifoFull,
  input  logic [BITS_PER_PIXEL-1:0]                   upstreamResponseFifoWriteData
);
  localparam int CNB = chunknum_bits(HACTIVE_BITS, CHUNK_BITS);
  localparam int RB  = request_bits(VACTIVE_BITS, HACTIVE_BITS, CHUNK_BITS);
  // Window ends are computed one bit wider so origin+size never wraps
  function automatic logic in_window(
    input logic [VACTIVE_BITS-1:0] row, input logic [CNB-1:0] chunk,
    input logic [VACTIVE_BITS-1:0] top, input logic [CNB-1:0] left,
    input logic [VACTIVE_BITS-1:0] rows, input logic [CNB-1:0] chunks
  );
    logic [VACTIVE_BITS:0] row_end;
    logic [CNB:0]          chunk_end;
    row_end   = {1'b0, top} + {1'b0, rows};
    chunk_end = {1'b0, left} + {1'b0, chunks};
    return row >= top && {1'b0, row} < row_end && chunk >= left && {1'b0, chunk} < chunk_end;
  endfunction
  req_state_e                req_q, req_d;
  logic                      ds_rd_q, ds_vld_q, byp_q, up_push_q, pend_push_q, win_q, win;
  logic                      up_full, pend_full, pend_empty, can_go, room;
  logic [RB-1:0]             req_hold_q, req_cur, up_data_q;
  logic [VACTIVE_BITS-1:0]   req_row;
  logic [CNB-1:0]            req_chunk;
  assign req_cur = ds_vld_q ? downstreamRequestFifoReadData : req_hold_q;
  assign {req_row, req_chunk} = req_cur;
  assign win    = byp_q || in_window(req_row, req_chunk, padTopRows, padLeftChunks, sourceRows, sourceChunks);
  assign room   = !up_full && !pend_full;
  assign can_go = !downstreamRequestFifoEmpty && room;
  assign downstreamRequestFifoReadEnable = ds_rd_q;
  always_comb
    req_d = (req_q == REQ_IDLE && can_go) ? REQ_READ :
            (req_q == REQ_READ && room)   ? REQ_STORE :
            (req_q == REQ_STORE)          ? REQ_IDLE : req_q;
  // Pushes are registered out of STORE; READ re-checks fullness so the lag is safe
  always_ff @(posedge scalerClock)
    if (reset) begin
      req_q       <= REQ_IDLE;
      ds_rd_q     <= 1'b0;
      ds_vld_q    <= 1'b0;
      byp_q       <= 1'b0;
      req_hold_q  <= '0;
      up_push_q   <= 1'b0;
      pend_push_q <= 1'b0;
      win_q       <= 1'b0;
      up_data_q   <= '0;
    end else begin
      req_q       <= req_d;
      ds_rd_q     <= req_q == REQ_IDLE && can_go;
      ds_vld_q    <= ds_rd_q;
      byp_q       <= req_q == REQ_IDLE ? bypass : byp_q;
      req_hold_q  <= req_cur;
      pend_push_q <= req_q == REQ_STORE;
      up_push_q   <= req_q == REQ_STORE && win;
      win_q       <= win;
      up_data_q   <= byp_q ? req_cur : {req_row - padTopRows, req_chunk - padLeftChunks};
    end
  SyncFifo #(.WIDTH(RB), .ADDR_BITS(REQ_FIFO_ADDR_BITS)) u_up_req (
    .clk(scalerClock), .rst(reset),
    .wr_en_i(up_push_q), .wr_data_i(up_data_q),
    .rd_en_i(upstreamRequestFifoReadEnable), .rd_data_o(upstreamRequestFifoReadData),
    .empty_o(upstreamRequestFifoEmpty), .full_o(up_full)
  );
  logic pend_rd, pend_win;
  SyncFifo #(.WIDTH(1), .ADDR_BITS(REQ_FIFO_ADDR_BITS)) u_pending (
    .clk(scalerClock), .rst(reset),
    .wr_en_i(pend_push_q), .wr_data_i(win_q),
    .rd_en_i(pend_rd), .rd_data_o(pend_win),
    .empty_o(pend_empty), .full_o(pend_full)
  );
  resp_state_e               resp_q, resp_d;
  logic [CHUNK_BITS-1:0]     cnt_q, cnt_d;
  logic                      is_pad_q, wr_q, sel_pad_q, issue, pix_rd, pix_empty, pix_full;
  logic [BITS_PER_PIXEL-1:0] pix_data;
  assign pend_rd = resp_q == RESP_IDLE && !pend_empty;
  assign issue   = resp_q == RESP_EMIT && !downstreamResponseFifoFull && (is_pad_q || !pix_empty);
  assign pix_rd  = issue && !is_pad_q;
  always_comb begin
    resp_d = pend_rd                 ? RESP_FETCH :
             resp_q == RESP_FETCH    ? RESP_EMIT  :
             (issue && (&cnt_q))     ? RESP_IDLE  : resp_q;
    cnt_d  = resp_q == RESP_FETCH ? '0 : issue ? cnt_q + CHUNK_BITS'(1) : cnt_q;
  end
  always_ff @(posedge scalerClock)
    if (reset) begin
      resp_q    <= RESP_IDLE;
      cnt_q     <= '0;
      is_pad_q  <= 1'b0;
      wr_q      <= 1'b0;
      sel_pad_q <= 1'b0;
    end else begin
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      is_pad_q  <= resp_q == RESP_FETCH ? !pend_win : is_pad_q;
      wr_q      <= issue;
      sel_pad_q <= is_pad_q;
    end
  SyncFifo #(.WIDTH(BITS_PER_PIXEL), .ADDR_BITS(PIX_FIFO_ADDR_BITS)) u_pix (
    .clk(scalerClock), .rst(reset),
    .wr_en_i(upstreamResponseFifoWriteEnable), .wr_data_i(upstreamResponseFifoWriteData),
    .rd_en_i(pix_rd), .rd_data_o(pix_data),
    .empty_o(pix_empty), .full_o(pix_full)
  );
  assign downstreamResponseFifoWriteEnable = wr_q;
  assign downstreamResponseFifoWriteData   = !wr_q ? '0 : sel_pad_q ? padColor : pix_data;
  assign upstreamResponseFifoFull          = pix_full || reset;
endmodule

// File: tb/tb_video_pad_crop_filter.sv
// tb_video_pad_crop_filter: directed vector table plus ordering, throttle, overflow and reset sequences
module tb_video_pad_crop_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset = 1'b1, bypass = 1'b0;
  logic [10:0] pad_top = 11'd2, src_rows = 11'd4;
  logic [5:0]  pad_left = 6'd1, src_chunks = 6'd2;
  logic [15:0] pad_color = 16'hA5C3;
  logic        ds_rd_en, ds_empty = 1'b1;
  logic [16:0] ds_rdata = '0;
  logic        ds_wr_en, ds_full = 1'b0;
  logic [15:0] ds_wdata;
  logic        up_rd_en = 1'b0, up_empty;
  logic [16:0] up_rdata;
  logic        up_wr_en = 1'b0, up_full;
  logic [15:0] up_wdata = '0;
  logic [16:0] dsq[$], upq[$];
  logic [15:0] outq[$];
  int          out_t[$];
  int          cyc = 0, checks = 0, failures = 0, tcnt = 0;
  logic        tog = 1'b0;
  video_pad_crop_filter dut (
    .scalerClock(clk), .reset(reset), .bypass(bypass),
    .padTopRows(pad_top), .padLeftChunks(pad_left), .sourceRows(src_rows), .sourceChunks(src_chunks),
    .padColor(pad_color),
    .downstreamRequestFifoReadEnable(ds_rd_en), .downstreamRequestFifoEmpty(ds_empty),
    .downstreamRequestFifoReadData(ds_rdata),
    .downstreamResponseFifoWriteEnable(ds_wr_en), .downstreamResponseFifoFull(ds_full),
    .downstreamResponseFifoWriteData(ds_wdata),
    .upstreamRequestFifoReadEnable(up_rd_en), .upstreamRequestFifoEmpty(up_empty),
    .upstreamRequestFifoReadData(up_rdata),
    .upstreamResponseFifoWriteEnable(up_wr_en), .upstreamResponseFifoFull(up_full),
    .upstreamResponseFifoWriteData(up_wdata)
  );
  always @(posedge clk) cyc <= cyc + 1;
  // Environment models: downstream request source, upstream request reader, response sink
  always @(negedge clk) begin
    if (ds_wr_en) begin
      outq.push_back(ds_wdata);
      out_t.push_back(cyc);
    end
    if (up_rd_en) upq.push_back(up_rdata);
    up_rd_en = !up_empty && !reset;
    if (ds_rd_en && dsq.size() > 0) ds_rdata = dsq.pop_front();
    ds_empty = dsq.size() == 0;
    tcnt++;
    ds_full = tog && ((tcnt / 3) % 2 == 1);
  end
  typedef struct {
    logic [10:0] top;
    logic [5:0]  left;
    logic [10:0] rows;
    logic [5:0]  chunks;
    logic        byp;
    logic [10:0] row;
    logic [5:0]  chunk;
    logic        pad;
    logic [16:0] up;
  } vec_t;
  vec_t vecs[15];
  function automatic vec_t mk(int top, int left, int rows, int chunks, int byp,
                              int row, int chunk, int pad, int urow, int uchunk);
    vec_t v;
    v.top = 11'(top); v.left = 6'(left); v.rows = 11'(rows); v.chunks = 6'(chunks);
    v.byp = 1'(byp); v.row = 11'(row); v.chunk = 6'(chunk); v.pad = 1'(pad);
    v.up = {11'(urow), 6'(uchunk)};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic wait_out(input string name, input int n, input int budget);
    int i = 0;
    while (outq.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_out_timeout"}, 32'(outq.size() >= n), 1);
  endtask
  task automatic wait_up(input string name, input int n, input int budget);
    int i = 0;
    while (upq.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_up_timeout"}, 32'(upq.size() >= n), 1);
  endtask
  task automatic feed(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      up_wr_en = 1'b1;
      up_wdata = 16'(base + 16'(i));
    end
    @(negedge clk);
    up_wr_en = 1'b0;
  endtask
  task automatic check_chunk(input string name, input int start, input logic pad, input logic [15:0] base);
    int bad = 0;
    logic [15:0] exp;
    for (int i = 0; i < 32; i++) begin
      exp = pad ? pad_color : 16'(base + 16'(i));
      if (start + i >= outq.size()) bad++;
      else if (outq[start+i] !== exp) bad++;
    end
    chk(name, bad, 0);
  endtask
  task automatic clear_logs();
    outq.delete();
    upq.delete();
    out_t.delete();
  endtask
  initial begin
    vecs[0]  = mk(2, 1, 4, 2, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(2, 1, 4, 2, 0, 3, 2, 0, 1, 1);
    vecs[2]  = mk(2, 1, 4, 2, 0, 2, 1, 0, 0, 0);
    vecs[3]  = mk(2, 1, 4, 2, 0, 5, 2, 0, 3, 1);
    vecs[4]  = mk(2, 1, 4, 2, 0, 6, 2, 1, 0, 0);
    vecs[5]  = mk(2, 1, 4, 2, 0, 5, 3, 1, 0, 0);
    vecs[6]  = mk(2, 1, 4, 2, 0, 1, 1, 1, 0, 0);
    vecs[7]  = mk(2, 1, 4, 2, 0, 2, 0, 1, 0, 0);
    vecs[8]  = mk(2047, 1, 4, 2, 0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(2047, 1, 4, 2, 0, 2047, 1, 0, 0, 0);
    vecs[10] = mk(2, 1, 4, 0, 0, 3, 1, 1, 0, 0);
    vecs[11] = mk(2, 1, 0, 2, 0, 3, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 5, 7, 0, 5, 7);
    vecs[13] = mk(2, 63, 4, 4, 0, 3, 63, 0, 1, 0);
    vecs[14] = mk(2, 63, 4, 4, 0, 3, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(ds_wr_en), 0);
    chk("rst_wdata", 32'(ds_wdata), 0);
    chk("rst_up_empty", 32'(up_empty), 1);
    chk("rst_ds_rd_en", 32'(ds_rd_en), 0);
    chk("rst_up_full", 32'(up_full), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("up_full_after_rst", 32'(up_full), 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      pad_top = vecs[k].top; pad_left = vecs[k].left;
      src_rows = vecs[k].rows; src_chunks = vecs[k].chunks; bypass = vecs[k].byp;
      clear_logs();
      repeat (2) @(negedge clk);
      dsq.push_back({vecs[k].row, vecs[k].chunk});
      if (!vecs[k].pad) begin
        wait_up($sformatf("v%0d", k), 1, 60);
        chk($sformatf("v%0d_up_req", k), 32'(upq.size() > 0 ? upq[0] : 17'h1ffff), 32'(vecs[k].up));
        feed(16'(k * 256), 32);
      end
      wait_out($sformatf("v%0d", k), 32, 300);
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_out_count", k), outq.size(), 32);
      chk($sformatf("v%0d_up_count", k), upq.size(), vecs[k].pad ? 0 : 1);
      check_chunk($sformatf("v%0d_pixels", k), 0, vecs[k].pad, 16'(k * 256));
      if (vecs[k].pad)
        chk($sformatf("v%0d_pad_burst", k), out_t.size() >= 32 ? out_t[31] - out_t[0] : -1, 31);
    end
    @(negedge clk);
    pad_top = 11'd2; pad_left = 6'd1; src_rows = 11'd4; src_chunks = 6'd2; bypass = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    dsq.push_back({11'd2, 6'd1});
    dsq.push_back({11'd2, 6'd3});
    dsq.push_back({11'd2, 6'd2});
    wait_up("ord", 2, 80);
    repeat (50) @(negedge clk);
    chk("ord_pad_waits", outq.size(), 0);
    feed(16'h1000, 32);
    feed(16'h2000, 32);
    wait_out("ord", 96, 400);
    repeat (20) @(negedge clk);
    chk("ord_out_count", outq.size(), 96);
    check_chunk("ord_chunk0", 0, 1'b0, 16'h1000);
    check_chunk("ord_chunk1", 32, 1'b1, 16'h0);
    check_chunk("ord_chunk2", 64, 1'b0, 16'h2000);
    chk("ord_up0", 32'(upq.size() > 0 ? upq[0] : 17'h1ffff), 32'({11'd0, 6'd0}));
    chk("ord_up1", 32'(upq.size() > 1 ? upq[1] : 17'h1ffff), 32'({11'd0, 6'd1}));
    clear_logs();
    tog = 1'b1;
    dsq.push_back({11'd3, 6'd2});
    wait_up("thr", 1, 60);
    feed(16'h3000, 32);
    wait_out("thr", 32, 400);
    repeat (20) @(negedge clk);
    tog = 1'b0;
    chk("thr_out_count", outq.size(), 32);
    check_chunk("thr_pixels", 0, 1'b0, 16'h3000);
    chk("thr_stretched", 32'(out_t.size() >= 32 && out_t[31] - out_t[0] > 31), 1);
    clear_logs();
    feed(16'h4000, 64);
    chk("pix_fifo_full", 32'(up_full), 1);
    feed(16'h5000, 4);
    dsq.push_back({11'd3, 6'd2});
    dsq.push_back({11'd3, 6'd2});
    wait_up("ovf", 2, 80);
    wait_out("ovf", 64, 400);
    repeat (20) @(negedge clk);
    chk("ovf_out_count", outq.size(), 64);
    check_chunk("ovf_chunk0", 0, 1'b0, 16'h4000);
    check_chunk("ovf_chunk1", 32, 1'b0, 16'h4020);
    chk("ovf_full_cleared", 32'(up_full), 0);
    clear_logs();
    dsq.push_back({11'd0, 6'd0});
    wait_out("rstm", 10, 100);
    reset = 1'b1;
    @(negedge clk);
    chk("rstm_wr_en", 32'(ds_wr_en), 0);
    chk("rstm_wdata", 32'(ds_wdata), 0);
    chk("rstm_up_empty", 32'(up_empty), 1);
    chk("rstm_ds_rd_en", 32'(ds_rd_en), 0);
    chk("rstm_up_full", 32'(up_full), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    dsq.push_back({11'd0, 6'd0});
    wait_out("rstm_after", 32, 100);
    repeat (20) @(negedge clk);
    chk("rstm_after_count", outq.size(), 32);
    check_chunk("rstm_after_pixels", 0, 1'b1, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
